// File: rtl/cpc_cfg_pkg.sv
// Shared definitions for the configuration loader: FSM encoding, default magic
// byte and the bit positions of the decoded feature flags inside cfg.
package cpc_cfg_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_READ   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_RUN    = 2'd3
  } cfg_state_e;

  localparam logic [7:0] CFG_MAGIC_DEFAULT = 8'hCF;

  localparam int unsigned VGA_BYTE  = 0;
  localparam int unsigned VGA_BIT   = 0;
  localparam int unsigned SCAN_BYTE = 0;
  localparam int unsigned SCAN_BIT  = 1;

  // Byte index covers magic + up to 16 payload bytes + checksum.
  localparam int unsigned CFG_IDX_W = 5;

endpackage

// File: rtl/cfg_read_timer.sv
// Paces SRAM byte reads: a READ_WAIT-clock down-counter whose terminal count
// raises a one-clock sample strobe, then reloads for the next byte.
module cfg_read_timer #(
  parameter int unsigned READ_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic sample_o
);

  localparam int unsigned CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_WAIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_LAST;
    end else if (run_i) begin
      if (cnt_q == '0) cnt_d = CNT_LAST;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign sample_o = run_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/cpc_config_loader.sv
// Power-up configuration loader: waits for SRAM to settle, reads a magic byte,
// N payload bytes and an XOR checksum, then releases the system reset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_SETTLE | power-up wait of WAIT_CYCLES clocks, system held in reset
// ST_READ   | reading image bytes 0..N+1 into the shadow buffer
// ST_CHECK  | one clock: validate image, publish shadow or default cfg
// ST_RUN    | system running, bus released, reload accepted
module cpc_config_loader
  import cpc_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W      = 21,
  parameter logic [ADDR_W-1:0] CFG_BASE = 21'h07FF00,
  parameter int unsigned CFG_BYTES   = 4,
  parameter int unsigned WAIT_CYCLES = 16000,
  parameter int unsigned READ_WAIT   = 2,
  parameter logic [7:0]  MAGIC       = CFG_MAGIC_DEFAULT,
  parameter logic [8*CFG_BYTES-1:0] DEFAULT_CFG = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reload,
  output logic [ADDR_W-1:0]        sram_addr,
  input  logic [7:0]               sram_data_i,
  output logic                     sram_we_n,
  output logic                     bus_owner,
  output logic                     pwon_reset_n,
  output logic                     cfg_valid,
  output logic [8*CFG_BYTES-1:0]   cfg,
  output logic                     vga_on,
  output logic                     scanlines_on
);

  localparam int unsigned WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam int unsigned SET_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned IDX_W     = CFG_IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CFG_BYTES + 1);

  cfg_state_e state_q, state_d;
  logic [SET_W-1:0]         settle_q, settle_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [8*CFG_BYTES-1:0]   shadow_q, shadow_d;
  logic [8*CFG_BYTES-1:0]   cfg_q, cfg_d;
  logic [7:0]               xor_q, xor_d;
  logic                     magic_ok_q, magic_ok_d;
  logic                     sum_ok_q, sum_ok_d;
  logic                     valid_q, valid_d;
  logic                     timer_load;
  logic                     sample;

  cfg_read_timer #(
    .READ_WAIT (READ_WAIT)
  ) u_read_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (timer_load),
    .run_i    (state_q == ST_READ),
    .sample_o (sample)
  );

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    cfg_d      = cfg_q;
    xor_d      = xor_q;
    magic_ok_d = magic_ok_q;
    sum_ok_d   = sum_ok_q;
    valid_d    = valid_q;
    timer_load = 1'b0;

    unique case (state_q)
      ST_SETTLE: begin
        if (settle_q == SET_W'(WAIT_LAST)) begin
          state_d    = ST_READ;
          settle_d   = '0;
          idx_d      = '0;
          xor_d      = '0;
          timer_load = 1'b1;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_READ: begin
        if (sample) begin
          if (idx_q == LAST_IDX) begin
            sum_ok_d = (xor_q == sram_data_i);
            idx_d    = '0;
            state_d  = ST_CHECK;
          end else begin
            xor_d = xor_q ^ sram_data_i;
            idx_d = idx_q + IDX_W'(1);
          end
          if (idx_q == '0) magic_ok_d = (sram_data_i == MAGIC);
          for (int k = 0; k < int'(CFG_BYTES); k++) begin
            if (idx_q == IDX_W'(k + 1)) shadow_d[8*k +: 8] = sram_data_i;
          end
        end
      end
      ST_CHECK: begin
        state_d = ST_RUN;
        if (magic_ok_q && sum_ok_q) begin
          cfg_d   = shadow_q;
          valid_d = 1'b1;
        end else begin
          cfg_d   = DEFAULT_CFG;
          valid_d = 1'b0;
        end
      end
      ST_RUN: begin
        // Sampled only here, so pulses during a load are dropped, not queued.
        if (reload) begin
          state_d    = ST_READ;
          idx_d      = '0;
          xor_d      = '0;
          timer_load = 1'b1;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SETTLE;
      settle_q   <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      cfg_q      <= DEFAULT_CFG;
      xor_q      <= '0;
      magic_ok_q <= 1'b0;
      sum_ok_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      cfg_q      <= cfg_d;
      xor_q      <= xor_d;
      magic_ok_q <= magic_ok_d;
      sum_ok_q   <= sum_ok_d;
      valid_q    <= valid_d;
    end
  end

  assign sram_addr    = CFG_BASE + ADDR_W'(idx_q);
  assign sram_we_n    = 1'b1;
  assign pwon_reset_n = (state_q == ST_RUN);
  assign bus_owner    = (state_q != ST_RUN);
  assign cfg_valid    = valid_q;
  assign cfg          = cfg_q;
  assign vga_on       = cfg_q[VGA_BYTE*8 + VGA_BIT];
  assign scanlines_on = cfg_q[SCAN_BYTE*8 + SCAN_BIT];

endmodule

// File: tb/tb_cpc_config_loader.sv
// Scoreboarded bench for cpc_config_loader: one instance at a normal base and
// one at the top of SRAM so its reads wrap to address 0.
module tb_cpc_config_loader;

  localparam int          N      = 2;
  localparam int          WAITC  = 8;
  localparam int          RW     = 2;
  localparam logic [20:0] BASE_A = 21'h07FF00;
  localparam logic [20:0] BASE_B = 21'h1FFFFF;
  localparam logic [15:0] DEFC   = 16'h1234;
  localparam int          LAT_PWR = WAITC + (N + 2) * RW + 1;
  localparam int          LAT_RLD = 1 + (N + 2) * RW + 1;

  typedef struct {
    logic [15:0] cfg;
    logic        valid;
    int          ref_cyc;
    int          lat;
  } exp_t;

  logic        clk, rst, reload;
  logic [20:0] addr_a, addr_b;
  logic [7:0]  data_a, data_b;
  logic        we_a, we_b, own_a, own_b, pwon_a, pwon_b, val_a, val_b;
  logic [15:0] cfg_a, cfg_b;
  logic        vga_a, vga_b, scan_a, scan_b;

  logic [7:0]  mem_a [4];
  logic [7:0]  mem_b [4];
  exp_t        q_a[$], q_b[$];
  int          cyc = 0;
  int          n_checks = 0, n_pass = 0;
  logic        we_low = 0, bad_wrap_addr = 0, saw0 = 0, saw2 = 0;
  logic        prev_a = 0, prev_b = 0;

  cpc_config_loader #(
    .ADDR_W(21), .CFG_BASE(BASE_A), .CFG_BYTES(N), .WAIT_CYCLES(WAITC),
    .READ_WAIT(RW), .MAGIC(8'hCF), .DEFAULT_CFG(DEFC)
  ) u_dut (
    .clk(clk), .rst(rst), .reload(reload), .sram_addr(addr_a),
    .sram_data_i(data_a), .sram_we_n(we_a), .bus_owner(own_a),
    .pwon_reset_n(pwon_a), .cfg_valid(val_a), .cfg(cfg_a),
    .vga_on(vga_a), .scanlines_on(scan_a)
  );

  cpc_config_loader #(
    .ADDR_W(21), .CFG_BASE(BASE_B), .CFG_BYTES(N), .WAIT_CYCLES(WAITC),
    .READ_WAIT(RW), .MAGIC(8'hCF), .DEFAULT_CFG(DEFC)
  ) u_wrap (
    .clk(clk), .rst(rst), .reload(reload), .sram_addr(addr_b),
    .sram_data_i(data_b), .sram_we_n(we_b), .bus_owner(own_b),
    .pwon_reset_n(pwon_b), .cfg_valid(val_b), .cfg(cfg_b),
    .vga_on(vga_b), .scanlines_on(scan_b)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: image at BASE_A, and at 1FFFFF,0,1,2 for the wrapping copy.
  logic [20:0] off_a;
  always_comb begin
    off_a  = addr_a - BASE_A;
    data_a = (off_a < 21'd4) ? mem_a[off_a[1:0]] : 8'hEE;
    if (addr_b == BASE_B)      data_b = mem_b[0];
    else if (addr_b < 21'd3)   data_b = mem_b[addr_b[1:0] + 2'd1];
    else                       data_b = 8'hEE;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_entry(input string tag, input exp_t e, input logic [15:0] c,
                             input logic v, input logic vga, input logic sl);
    check({tag, "_cfg"},       32'(c),   32'(e.cfg));
    check({tag, "_valid"},     32'(v),   32'(e.valid));
    check({tag, "_vga_on"},    32'(vga), 32'(e.cfg[0]));
    check({tag, "_scanlines"}, 32'(sl),  32'(e.cfg[1]));
    check({tag, "_latency"},   32'(cyc - e.ref_cyc), 32'(e.lat));
  endtask

  // Monitors: a rising pwon_reset_n marks a completed load.
  always @(negedge clk) begin
    if (!rst && pwon_a && !prev_a) begin
      if (q_a.size() == 0) check("a_unexpected_load", 32'd1, 32'd0);
      else check_entry("a", q_a.pop_front(), cfg_a, val_a, vga_a, scan_a);
    end
    if (!rst && pwon_b && !prev_b) begin
      if (q_b.size() == 0) check("b_unexpected_load", 32'd1, 32'd0);
      else check_entry("b", q_b.pop_front(), cfg_b, val_b, vga_b, scan_b);
    end
    prev_a = pwon_a;
    prev_b = pwon_b;
    if (we_a !== 1'b1 || we_b !== 1'b1) we_low = 1;
    if (!rst && own_b) begin
      if (addr_b == 21'd0) saw0 = 1;
      if (addr_b == 21'd2) saw2 = 1;
      if (!(addr_b == BASE_B || addr_b <= 21'd2)) bad_wrap_addr = 1;
    end
  end

  task automatic set_mem(input logic [7:0] b0, b1, b2, b3);
    mem_a[0] = b0; mem_a[1] = b1; mem_a[2] = b2; mem_a[3] = b3;
  endtask

  task automatic check_reset();
    check("rst_addr_a",  32'(addr_a), 32'(BASE_A));
    check("rst_addr_b",  32'(addr_b), 32'(BASE_B));
    check("rst_we_n",    32'(we_a),   32'd1);
    check("rst_owner",   32'(own_a),  32'd1);
    check("rst_pwon",    32'(pwon_a), 32'd0);
    check("rst_valid",   32'(val_a),  32'd0);
    check("rst_cfg_a",   32'(cfg_a),  32'(DEFC));
    check("rst_cfg_b",   32'(cfg_b),  32'(DEFC));
  endtask

  task automatic push_both(input logic [15:0] ca, input logic va, input int r, input int lat);
    exp_t e;
    e.cfg = ca; e.valid = va; e.ref_cyc = r; e.lat = lat;
    q_a.push_back(e);
    e.cfg = 16'h2211; e.valid = 1'b1;
    q_b.push_back(e);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1; rst = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_rst(input logic [15:0] ca, input logic va);
    rst = 0;
    push_both(ca, va, cyc, LAT_PWR);
  endtask

  task automatic wait_drain(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (q_a.size() == 0 && q_b.size() == 0) break;
    end
    if (i == max_cyc) begin
      check("drain_timeout", 32'(q_a.size() + q_b.size()), 32'd0);
      q_a.delete(); q_b.delete();
    end
  endtask

  initial begin
    int c;
    rst = 1; reload = 0;
    set_mem(8'hCF, 8'h03, 8'hA5, 8'h69);
    mem_b[0] = 8'hCF; mem_b[1] = 8'h11; mem_b[2] = 8'h22; mem_b[3] = 8'hFC;
    repeat (3) @(posedge clk);
    #1;
    check_reset();

    // Valid image.
    release_rst(16'hA503, 1'b1);
    wait_drain(40);

    // Bad magic with consistent checksum; a reload pulse during SETTLE is ignored.
    set_mem(8'h00, 8'h03, 8'hA5, 8'hA6);
    pulse_rst();
    release_rst(DEFC, 1'b0);
    repeat (3) @(posedge clk);
    #1; reload = 1;
    @(posedge clk); #1; reload = 0;
    wait_drain(40);

    // Bad checksum.
    set_mem(8'hCF, 8'h03, 8'hA5, 8'h00);
    pulse_rst();
    release_rst(DEFC, 1'b0);
    wait_drain(40);

    // Valid again, then reload with new contents.
    set_mem(8'hCF, 8'h03, 8'hA5, 8'h69);
    pulse_rst();
    release_rst(16'hA503, 1'b1);
    wait_drain(40);
    set_mem(8'hCF, 8'h00, 8'hA5, 8'h6A);
    @(posedge clk); #1;
    reload = 1; c = cyc;
    push_both(16'hA500, 1'b1, c, LAT_RLD);
    @(posedge clk); #1; reload = 0;
    check("reload_pwon_fall", 32'(pwon_a), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (pwon_a) break;
      check("reload_cfg_held",   32'(cfg_a), 32'hA503);
      check("reload_valid_held", 32'(val_a), 32'd1);
      @(posedge clk); #1;
    end
    wait_drain(20);

    // Reset during the third byte read, then a full reload from SETTLE.
    set_mem(8'hCF, 8'h03, 8'hA5, 8'h69);
    pulse_rst();
    rst = 0;
    repeat (WAITC + 2 * RW + 1) @(posedge clk);
    #1;
    check("mid_load_addr", 32'(addr_a), 32'(BASE_A + 21'd2));
    rst = 1; #1;
    check_reset();
    @(posedge clk); #1;
    release_rst(16'hA503, 1'b1);
    wait_drain(40);

    // Reload held high: one reload per RUN entry.
    @(posedge clk); #1;
    reload = 1; c = cyc;
    push_both(16'hA503, 1'b1, c, LAT_RLD);
    push_both(16'hA503, 1'b1, c + LAT_RLD, LAT_RLD);
    repeat (2 * LAT_RLD) @(posedge clk);
    #1; reload = 0;
    wait_drain(30);
    repeat (5) @(posedge clk);
    #1;
    check("held_reload_stops_pwon", 32'(pwon_a), 32'd1);
    check("held_reload_stops_own",  32'(own_a),  32'd0);

    check("we_n_never_low",     32'(we_low),        32'd0);
    check("wrap_addr_in_range", 32'(bad_wrap_addr), 32'd0);
    check("wrap_saw_addr0",     32'(saw0),          32'd1);
    check("wrap_saw_addr2",     32'(saw2),          32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
